// File: rtl/id_ex_stage_register_pkg.sv
// Shared widths and the decode control bundle for the ID/EX pipeline register.
// Imported by the interface, the bypass mux and the stage register itself.
package id_ex_stage_register_pkg;

   localparam int REG_ADDR_W = 3;
   localparam int DATA_W     = 16;
   localparam int IMM_W      = 8;
   localparam int ALUOP_W    = 3;
   localparam int CNT_W      = 16;

   typedef struct packed {
      logic [ALUOP_W-1:0] aluOp;
      logic               regWrite;
      logic               regWriteDataSel;
      logic               aluInputBMuxSel;
      logic               memWrite;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_register_if.sv
// Decode-side, writeback-side and hazard signals crossing the ID/EX boundary.
// master drives the decode inputs; slave is the stage register.
interface id_ex_stage_register_if;
   import id_ex_stage_register_pkg::*;

   logic [REG_ADDR_W-1:0] stage2_r1Address;
   logic [REG_ADDR_W-1:0] stage2_r2Address;
   logic [REG_ADDR_W-1:0] stage2_dest;
   logic [DATA_W-1:0]     stage2_r1Data;
   logic [DATA_W-1:0]     stage2_r2Data;
   logic [IMM_W-1:0]      stage2_imm;
   logic [ALUOP_W-1:0]    stage2_aluOp;
   logic                  stage2_regWrite;
   logic                  stage2_regWriteDataSel;
   logic                  stage2_aluInputBMuxSel;
   logic                  stage2_memWrite;
   logic                  stall;
   logic                  flush;
   logic                  Mem_Wb_regWrite;
   logic [REG_ADDR_W-1:0] Mem_Wb_dest;
   logic [DATA_W-1:0]     Mem_Wb_data;

   logic [REG_ADDR_W-1:0] Id_Ex_r1Address;
   logic [REG_ADDR_W-1:0] Id_Ex_r2Address;
   logic [REG_ADDR_W-1:0] Id_Ex_Dest;
   logic [DATA_W-1:0]     Id_Ex_r1Data;
   logic [DATA_W-1:0]     Id_Ex_r2Data;
   logic [IMM_W-1:0]      Id_Ex_imm;
   logic [ALUOP_W-1:0]    Id_Ex_aluOp;
   logic                  Id_Ex_regWrite;
   logic                  Id_Ex_regWriteDataSel;
   logic                  Id_Ex_aluInputBMuxSel;
   logic                  Id_Ex_memWrite;
   logic                  Id_Ex_valid;
   logic                  pcHold;
   logic                  ifIdHold;
   logic [CNT_W-1:0]      bubbleCount;

   modport master (
      output stage2_r1Address, stage2_r2Address, stage2_dest,
      output stage2_r1Data, stage2_r2Data, stage2_imm,
      output stage2_aluOp, stage2_regWrite, stage2_regWriteDataSel,
      output stage2_aluInputBMuxSel, stage2_memWrite,
      output stall, flush, Mem_Wb_regWrite, Mem_Wb_dest, Mem_Wb_data,
      input  Id_Ex_r1Address, Id_Ex_r2Address, Id_Ex_Dest,
      input  Id_Ex_r1Data, Id_Ex_r2Data, Id_Ex_imm, Id_Ex_aluOp,
      input  Id_Ex_regWrite, Id_Ex_regWriteDataSel, Id_Ex_aluInputBMuxSel,
      input  Id_Ex_memWrite, Id_Ex_valid, pcHold, ifIdHold, bubbleCount
   );

   modport slave (
      input  stage2_r1Address, stage2_r2Address, stage2_dest,
      input  stage2_r1Data, stage2_r2Data, stage2_imm,
      input  stage2_aluOp, stage2_regWrite, stage2_regWriteDataSel,
      input  stage2_aluInputBMuxSel, stage2_memWrite,
      input  stall, flush, Mem_Wb_regWrite, Mem_Wb_dest, Mem_Wb_data,
      output Id_Ex_r1Address, Id_Ex_r2Address, Id_Ex_Dest,
      output Id_Ex_r1Data, Id_Ex_r2Data, Id_Ex_imm, Id_Ex_aluOp,
      output Id_Ex_regWrite, Id_Ex_regWriteDataSel, Id_Ex_aluInputBMuxSel,
      output Id_Ex_memWrite, Id_Ex_valid, pcHold, ifIdHold, bubbleCount
   );

endinterface

// File: rtl/id_ex_stage_register_wb_bypass_mux.sv
// Per-operand writeback bypass: substitutes the data being written back this
// cycle when it targets the register being read. Register 0 is not special.
module id_ex_stage_register_wb_bypass_mux
   import id_ex_stage_register_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0]     rd_data,
   input  logic                  wb_en,
   input  logic [REG_ADDR_W-1:0] wb_dest,
   input  logic [DATA_W-1:0]     wb_data,
   output logic [DATA_W-1:0]     sel_data
);

   logic hit;

   assign hit      = wb_en && (wb_dest == rd_addr);
   assign sel_data = hit ? wb_data : rd_data;

endmodule

// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register with stall/flush bubble insertion, writeback bypass
// on both read operands and a saturating count of inserted bubbles.
module id_ex_stage_register
   import id_ex_stage_register_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   id_ex_stage_register_if.slave  bus
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

   ctrl_t                 ctrl_p0;
   logic                  bubble_p0;
   logic [DATA_W-1:0]     r1_data_p0;
   logic [DATA_W-1:0]     r2_data_p0;

   ctrl_t                 ctrl_p1;
   logic                  vld_p1;
   logic [REG_ADDR_W-1:0] r1_addr_p1;
   logic [REG_ADDR_W-1:0] r2_addr_p1;
   logic [REG_ADDR_W-1:0] dest_p1;
   logic [DATA_W-1:0]     r1_data_p1;
   logic [DATA_W-1:0]     r2_data_p1;
   logic [IMM_W-1:0]      imm_p1;
   logic [CNT_W-1:0]      bubble_cnt_p1;

   // p0: decode-side inputs, bypass selection and bubble decision
   assign ctrl_p0 = '{aluOp:           bus.stage2_aluOp,
                      regWrite:        bus.stage2_regWrite,
                      regWriteDataSel: bus.stage2_regWriteDataSel,
                      aluInputBMuxSel: bus.stage2_aluInputBMuxSel,
                      memWrite:        bus.stage2_memWrite};
   assign bubble_p0 = bus.stall | bus.flush;

   id_ex_stage_register_wb_bypass_mux u_byp_r1 (
      .rd_addr  (bus.stage2_r1Address),
      .rd_data  (bus.stage2_r1Data),
      .wb_en    (bus.Mem_Wb_regWrite),
      .wb_dest  (bus.Mem_Wb_dest),
      .wb_data  (bus.Mem_Wb_data),
      .sel_data (r1_data_p0)
   );

   id_ex_stage_register_wb_bypass_mux u_byp_r2 (
      .rd_addr  (bus.stage2_r2Address),
      .rd_data  (bus.stage2_r2Data),
      .wb_en    (bus.Mem_Wb_regWrite),
      .wb_dest  (bus.Mem_Wb_dest),
      .wb_data  (bus.Mem_Wb_data),
      .sel_data (r2_data_p0)
   );

   // Flush wins over stall: a squashed fetch must redirect, not hold
   assign bus.pcHold   = bus.stall & ~bus.flush & ~reset;
   assign bus.ifIdHold = bus.stall & ~bus.flush & ~reset;

   // p1: ID/EX register; a bubble zeroes controls but still carries operands
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_p1       <= CTRL_NOP;
         vld_p1        <= 1'b0;
         r1_addr_p1    <= '0;
         r2_addr_p1    <= '0;
         dest_p1       <= '0;
         r1_data_p1    <= '0;
         r2_data_p1    <= '0;
         imm_p1        <= '0;
         bubble_cnt_p1 <= '0;
      end else begin
         ctrl_p1    <= bubble_p0 ? CTRL_NOP : ctrl_p0;
         vld_p1     <= ~bubble_p0;
         r1_addr_p1 <= bus.stage2_r1Address;
         r2_addr_p1 <= bus.stage2_r2Address;
         dest_p1    <= bus.stage2_dest;
         r1_data_p1 <= r1_data_p0;
         r2_data_p1 <= r2_data_p0;
         imm_p1     <= bus.stage2_imm;
         if (bubble_p0) begin
            bubble_cnt_p1 <= sat_inc(bubble_cnt_p1);
         end
      end
   end

   assign bus.Id_Ex_r1Address       = r1_addr_p1;
   assign bus.Id_Ex_r2Address       = r2_addr_p1;
   assign bus.Id_Ex_Dest            = dest_p1;
   assign bus.Id_Ex_r1Data          = r1_data_p1;
   assign bus.Id_Ex_r2Data          = r2_data_p1;
   assign bus.Id_Ex_imm             = imm_p1;
   assign bus.Id_Ex_aluOp           = ctrl_p1.aluOp;
   assign bus.Id_Ex_regWrite        = ctrl_p1.regWrite;
   assign bus.Id_Ex_regWriteDataSel = ctrl_p1.regWriteDataSel;
   assign bus.Id_Ex_aluInputBMuxSel = ctrl_p1.aluInputBMuxSel;
   assign bus.Id_Ex_memWrite        = ctrl_p1.memWrite;
   assign bus.Id_Ex_valid           = vld_p1;
   assign bus.bubbleCount           = bubble_cnt_p1;

endmodule

// File: tb/tb_id_ex_stage_register.sv
// Bench for id_ex_stage_register: directed scenarios plus randomized traffic
// checked against a per-edge behavioural model of the stage register.
module tb_id_ex_stage_register;
   import id_ex_stage_register_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   id_ex_stage_register_if bus ();

   id_ex_stage_register dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [2:0]  r1a, r2a, dest;
      logic [15:0] r1d, r2d;
      logic [7:0]  imm;
      logic [2:0]  aluop;
      logic        rw, rwds, bsel, mw;
      logic        stall, flush, rst;
      logic        wb_en;
      logic [2:0]  wb_dest;
      logic [15:0] wb_data;
   } stim_t;

   typedef struct packed {
      logic [2:0]  r1a, r2a, dest;
      logic [15:0] r1d, r2d;
      logic [7:0]  imm;
      logic [2:0]  aluop;
      logic        rw, rwds, bsel, mw, valid;
      logic [15:0] cnt;
   } obs_t;

   int   n_cmp  = 0;
   int   n_fail = 0;
   obs_t m      = '0;
   logic hold_pc, hold_ifid;

   function automatic obs_t dut_obs();
      obs_t o;
      o.r1a = bus.Id_Ex_r1Address;  o.r2a = bus.Id_Ex_r2Address;
      o.dest = bus.Id_Ex_Dest;      o.r1d = bus.Id_Ex_r1Data;
      o.r2d = bus.Id_Ex_r2Data;     o.imm = bus.Id_Ex_imm;
      o.aluop = bus.Id_Ex_aluOp;    o.rw = bus.Id_Ex_regWrite;
      o.rwds = bus.Id_Ex_regWriteDataSel;
      o.bsel = bus.Id_Ex_aluInputBMuxSel;
      o.mw = bus.Id_Ex_memWrite;    o.valid = bus.Id_Ex_valid;
      o.cnt = bus.bubbleCount;
      return o;
   endfunction

   function automatic stim_t idle_stim();
      stim_t s;
      s.r1a = 0; s.r2a = 0; s.dest = 0; s.r1d = 0; s.r2d = 0; s.imm = 0;
      s.aluop = 0; s.rw = 0; s.rwds = 0; s.bsel = 0; s.mw = 0;
      s.stall = 0; s.flush = 0; s.rst = 0;
      s.wb_en = 0; s.wb_dest = 0; s.wb_data = 0;
      return s;
   endfunction

   function automatic stim_t rand_stim();
      stim_t s;
      s.r1a = 3'($urandom); s.r2a = 3'($urandom); s.dest = 3'($urandom);
      s.r1d = 16'($urandom); s.r2d = 16'($urandom); s.imm = 8'($urandom);
      s.aluop = 3'($urandom); s.rw = 1'($urandom); s.rwds = 1'($urandom);
      s.bsel = 1'($urandom); s.mw = 1'($urandom);
      s.stall = ($urandom_range(0, 3) == 0);
      s.flush = ($urandom_range(0, 6) == 0);
      s.rst   = ($urandom_range(0, 30) == 0);
      s.wb_en = 1'($urandom);
      case ($urandom_range(0, 2))
         0:       s.wb_dest = s.r1a;
         1:       s.wb_dest = s.r2a;
         default: s.wb_dest = 3'($urandom);
      endcase
      s.wb_data = 16'($urandom);
      return s;
   endfunction

   // Reference: what the register holds after one rising edge with inputs s
   function automatic void model_step(input stim_t s);
      bit bub;
      bub = s.stall || s.flush;
      if (s.rst) begin
         m = '0;
      end else begin
         m.r1a = s.r1a; m.r2a = s.r2a; m.dest = s.dest; m.imm = s.imm;
         m.r1d = (s.wb_en && s.wb_dest == s.r1a) ? s.wb_data : s.r1d;
         m.r2d = (s.wb_en && s.wb_dest == s.r2a) ? s.wb_data : s.r2d;
         m.aluop = bub ? 3'd0 : s.aluop;
         m.rw    = bub ? 1'b0 : s.rw;
         m.rwds  = bub ? 1'b0 : s.rwds;
         m.bsel  = bub ? 1'b0 : s.bsel;
         m.mw    = bub ? 1'b0 : s.mw;
         m.valid = !bub;
         if (bub && m.cnt < 16'hFFFF) m.cnt = m.cnt + 16'd1;
      end
   endfunction

   task automatic drive(input stim_t s);
      reset = s.rst;
      bus.stage2_r1Address = s.r1a;   bus.stage2_r2Address = s.r2a;
      bus.stage2_dest = s.dest;       bus.stage2_r1Data = s.r1d;
      bus.stage2_r2Data = s.r2d;      bus.stage2_imm = s.imm;
      bus.stage2_aluOp = s.aluop;     bus.stage2_regWrite = s.rw;
      bus.stage2_regWriteDataSel = s.rwds;
      bus.stage2_aluInputBMuxSel = s.bsel;
      bus.stage2_memWrite = s.mw;
      bus.stall = s.stall;            bus.flush = s.flush;
      bus.Mem_Wb_regWrite = s.wb_en;  bus.Mem_Wb_dest = s.wb_dest;
      bus.Mem_Wb_data = s.wb_data;
      #1;
      hold_pc   = bus.pcHold;
      hold_ifid = bus.ifIdHold;
      @(posedge clk);
      model_step(s);
      #1;
   endtask

   task automatic test_reset();
      stim_t s = rand_stim();
      s.rst = 1; s.stall = 1; s.flush = 0;
      drive(s);
      n_cmp++; if (hold_pc !== 1'b0) begin n_fail++; $display("FAIL reset_pchold: got %b want 0", hold_pc); end
      n_cmp++; if (dut_obs() !== obs_t'(0)) begin n_fail++; $display("FAIL reset_state: got %h want 0", dut_obs()); end
   endtask

   task automatic test_load();
      stim_t s = idle_stim();
      s.dest = 3'd5; s.r1d = 16'h1234; s.rw = 1; s.r1a = 3'd2; s.imm = 8'hA5;
      drive(s);
      n_cmp++; if (bus.Id_Ex_Dest !== 3'd5) begin n_fail++; $display("FAIL load_dest: got %0d want 5", bus.Id_Ex_Dest); end
      n_cmp++; if (bus.Id_Ex_r1Data !== 16'h1234) begin n_fail++; $display("FAIL load_r1data: got %h want 1234", bus.Id_Ex_r1Data); end
      n_cmp++; if ({bus.Id_Ex_regWrite, bus.Id_Ex_valid} !== 2'b11) begin n_fail++; $display("FAIL load_rw_valid: got %b want 11", {bus.Id_Ex_regWrite, bus.Id_Ex_valid}); end
      n_cmp++; if (dut_obs() !== m) begin n_fail++; $display("FAIL load_all: got %h want %h", dut_obs(), m); end
   endtask

   task automatic test_stall();
      stim_t s = idle_stim();
      s.stall = 1; s.rw = 1; s.mw = 1; s.aluop = 3'd6; s.r1d = 16'h5555;
      drive(s);
      n_cmp++; if ({hold_pc, hold_ifid} !== 2'b11) begin n_fail++; $display("FAIL stall_hold: got %b want 11", {hold_pc, hold_ifid}); end
      n_cmp++; if ({bus.Id_Ex_regWrite, bus.Id_Ex_memWrite, bus.Id_Ex_valid} !== 3'b000) begin n_fail++; $display("FAIL stall_ctrl: got %b want 000", {bus.Id_Ex_regWrite, bus.Id_Ex_memWrite, bus.Id_Ex_valid}); end
      n_cmp++; if (bus.bubbleCount !== 16'd1) begin n_fail++; $display("FAIL stall_count: got %0d want 1", bus.bubbleCount); end
      n_cmp++; if (bus.Id_Ex_r1Data !== 16'h5555) begin n_fail++; $display("FAIL stall_data: got %h want 5555", bus.Id_Ex_r1Data); end
   endtask

   task automatic test_bypass();
      stim_t s = idle_stim();
      s.r2a = 3'd3; s.wb_en = 1; s.wb_dest = 3'd3; s.wb_data = 16'hBEEF; s.r2d = 16'h0000;
      s.r1a = 3'd1; s.r1d = 16'h1111;
      drive(s);
      n_cmp++; if (bus.Id_Ex_r2Data !== 16'hBEEF) begin n_fail++; $display("FAIL byp_r2_hit: got %h want beef", bus.Id_Ex_r2Data); end
      n_cmp++; if (bus.Id_Ex_r1Data !== 16'h1111) begin n_fail++; $display("FAIL byp_r1_miss: got %h want 1111", bus.Id_Ex_r1Data); end
      s.wb_en = 0;
      drive(s);
      n_cmp++; if (bus.Id_Ex_r2Data !== 16'h0000) begin n_fail++; $display("FAIL byp_r2_off: got %h want 0000", bus.Id_Ex_r2Data); end
      s = idle_stim();
      s.r1a = 3'd0; s.r2a = 3'd0; s.r1d = 16'h0102; s.r2d = 16'h0304;
      s.wb_en = 1; s.wb_dest = 3'd0; s.wb_data = 16'hCAFE; s.stall = 1;
      drive(s);
      n_cmp++; if ({bus.Id_Ex_r1Data, bus.Id_Ex_r2Data} !== 32'hCAFECAFE) begin n_fail++; $display("FAIL byp_reg0_stall: got %h want cafecafe", {bus.Id_Ex_r1Data, bus.Id_Ex_r2Data}); end
   endtask

   task automatic test_flush_stall();
      stim_t s = idle_stim();
      logic [15:0] want_cnt = m.cnt + 16'd1;
      s.stall = 1; s.flush = 1; s.rw = 1; s.mw = 1; s.bsel = 1;
      drive(s);
      n_cmp++; if ({hold_pc, hold_ifid} !== 2'b00) begin n_fail++; $display("FAIL fs_hold: got %b want 00", {hold_pc, hold_ifid}); end
      n_cmp++; if (bus.Id_Ex_valid !== 1'b0) begin n_fail++; $display("FAIL fs_valid: got %b want 0", bus.Id_Ex_valid); end
      n_cmp++; if (bus.bubbleCount !== want_cnt) begin n_fail++; $display("FAIL fs_count: got %0d want %0d", bus.bubbleCount, want_cnt); end
      s.stall = 0;
      drive(s);
      n_cmp++; if (dut_obs() !== m) begin n_fail++; $display("FAIL flush_only: got %h want %h", dut_obs(), m); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         stim_t s = rand_stim();
         s.stall = 1; s.flush = 0; s.rst = 0;
         drive(s);
         n_cmp++; if ({hold_pc, hold_ifid} !== 2'b11) begin n_fail++; $display("FAIL b2b_hold[%0d]: got %b want 11", i, {hold_pc, hold_ifid}); end
         n_cmp++; if (dut_obs() !== m) begin n_fail++; $display("FAIL b2b_state[%0d]: got %h want %h", i, dut_obs(), m); end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         stim_t s = rand_stim();
         logic want_hold = s.stall & ~s.flush & ~s.rst;
         drive(s);
         n_cmp++; if ({hold_pc, hold_ifid} !== {2{want_hold}}) begin n_fail++; $display("FAIL rand_hold[%0d]: got %b want %b", i, {hold_pc, hold_ifid}, {2{want_hold}}); end
         n_cmp++; if (dut_obs() !== m) begin n_fail++; $display("FAIL rand_state[%0d]: got %h want %h", i, dut_obs(), m); end
      end
   endtask

   task automatic test_reset_mid();
      stim_t s = idle_stim();
      s.rst = 1;
      drive(s);
      s = rand_stim(); s.rst = 0; s.stall = 0; s.flush = 0;
      drive(s);
      for (int i = 0; i < 7; i++) begin
         s = rand_stim(); s.rst = 0; s.stall = 1; s.flush = 0;
         drive(s);
      end
      s = rand_stim(); s.rst = 0; s.stall = 0; s.flush = 0; s.rw = 1;
      drive(s);
      n_cmp++; if (bus.bubbleCount !== 16'd7 || bus.Id_Ex_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre: got cnt %0d valid %b want 7 1", bus.bubbleCount, bus.Id_Ex_valid); end
      s = rand_stim(); s.rst = 1; s.stall = 1; s.flush = 0;
      drive(s);
      n_cmp++; if (hold_pc !== 1'b0 || hold_ifid !== 1'b0) begin n_fail++; $display("FAIL rmid_hold: got %b%b want 00", hold_pc, hold_ifid); end
      n_cmp++; if (dut_obs() !== obs_t'(0)) begin n_fail++; $display("FAIL rmid_state: got %h want 0", dut_obs()); end
      s = rand_stim(); s.rst = 0; s.stall = 0; s.flush = 0;
      drive(s);
      n_cmp++; if (dut_obs() !== m || bus.Id_Ex_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_first_load: got %h want %h", dut_obs(), m); end
   endtask

   task automatic test_saturation();
      stim_t s = idle_stim();
      s.rst = 1;
      drive(s);
      s.rst = 0; s.stall = 1;
      for (int i = 0; i < 65534; i++) drive(s);
      n_cmp++; if (bus.bubbleCount !== 16'hFFFE) begin n_fail++; $display("FAIL sat_preload: got %h want fffe", bus.bubbleCount); end
      for (int i = 0; i < 3; i++) begin
         drive(s);
         n_cmp++; if (bus.bubbleCount !== 16'hFFFF) begin n_fail++; $display("FAIL sat_step[%0d]: got %h want ffff", i, bus.bubbleCount); end
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_stall();
      test_bypass();
      test_flush_stall();
      test_back_to_back();
      test_random();
      test_reset_mid();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
